interval_arbiter: RTL

INTERVAL_ARBITER -- requirements
Module: interval_arbiter

---
 rtl/interval_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/interval_arbiter.sv
// rtl/interval_arbiter.sv - round-robin arbiter granting a shared interval counter to one requester at a time
// Optional macro INTERVAL_ARBITER_FAST_REGRANT_EN: regrant on the completion edge without an idle cycle.
module interval_arbiter #(
    parameter int requesters       = 4,
    parameter int counter_width    = 8,
    parameter int counter_overflow = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [requesters-1:0]    request,
    input  logic                     abort,
    output logic [requesters-1:0]    grant,
    output logic                     busy,
    output logic [counter_width-1:0] count,
    output logic [requesters-1:0]    done
);

    localparam int idx_w = (requesters > 1) ? $clog2(requesters) : 1;
    localparam logic [counter_width-1:0] last_count = counter_width'(counter_overflow - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic [idx_w-1:0]        last_idx;
    logic [idx_w-1:0]        win_idx;
    logic                    win_found;
    logic [requesters-1:0]   cand;
    logic [requesters-1:0]   win_onehot;

    function automatic logic [idx_w-1:0] rr_idx(input logic [idx_w-1:0] base, input int k);
        return idx_w'((int'(base) + k) % requesters);
    endfunction

    // Current owner is masked out so a fast regrant always moves on to someone else.
    assign cand       = request & ~grant;
    assign win_onehot = requesters'(1) << win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = last_idx;
        for (int k = 1; k <= requesters; k++) begin
            if (!win_found && cand[rr_idx(last_idx, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(last_idx, k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            count    <= '0;
            done     <= '0;
            last_idx <= idx_w'(requesters - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= RUN;
                        grant    <= win_onehot;
                        busy     <= 1'b1;
                        count    <= '0;
                        last_idx <= win_idx;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == last_count) begin
                        done  <= grant;
                        count <= '0;
`ifdef INTERVAL_ARBITER_FAST_REGRANT_EN
                        if (win_found) begin
                            grant    <= win_onehot;
                            last_idx <= win_idx;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
`endif
                    end else begin
                        count <= count + counter_width'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
